// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, tag and state types for the MAC output path
package mac_pkg;
    localparam int AW    = 20;
    localparam int OW    = 24;
    localparam int TILE  = 4;
    localparam int DEPTH = 16;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_CLEAR  = 2'd1,
        WB_ACTIVE = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] addr;
        logic       acc;
    } tag_t;
endpackage

// File: rtl/tag_delay.sv
// rtl/tag_delay.sv - LAT-deep shift register that aligns row tags with array results
module tag_delay
    import mac_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic CLK,
    input  logic RST,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic busy
);
    tag_t stage [LAT];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[LAT-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) busy = busy | stage[i].valid;
    end
endmodule

// File: rtl/omem_writeback.sv
// rtl/omem_writeback.sv - tags MAC array rows and writes or accumulates them into output memory
module omem_writeback #(
    parameter int LAT = 3,
    parameter int AW  = mac_pkg::AW,
    parameter int OW  = mac_pkg::OW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CLR_REQ,
    input  logic            START_CALC,
    input  logic [3:0]      ODST,
    input  logic            ACC,
    input  logic [4*AW-1:0] ARR_DATA,
    input  logic [4*OW-1:0] OM_RDATA,
    output logic            OM_REN,
    output logic            OM_WEN,
    output logic [3:0]      OM_RADDR,
    output logic [3:0]      OM_WADDR,
    output logic [4*OW-1:0] OM_WDATA,
    output logic            Tile_Done,
    output logic            BUSY,
    output logic            ERR
);
    localparam int RW = $clog2(mac_pkg::TILE);
    localparam int CW = $clog2(mac_pkg::DEPTH);

    mac_pkg::wb_state_t state, state_nxt;
    mac_pkg::tag_t      tag_in, tag_out;

    logic [RW-1:0]   row_cnt;
    logic [1:0]      base_q;
    logic            acc_q;
    logic [CW-1:0]   clr_cnt;
    logic            push, err_set, sr_busy;
    logic            r_valid, r_acc, done_q, err_q;
    logic [3:0]      r_addr;
    logic [4*OW-1:0] r_data, arr_ext, acc_sum;
    logic            unused_odst;

    assign unused_odst = ^ODST[1:0];

    tag_delay #(.LAT(LAT)) u_tag_delay (
        .CLK     (CLK),
        .RST     (RST),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .busy    (sr_busy)
    );

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        err_set   = 1'b0;
        case (state)
            mac_pkg::WB_IDLE: begin
                if (CLR_REQ) begin
                    state_nxt = mac_pkg::WB_CLEAR;
                    err_set   = START_CALC;
                end else if (START_CALC) begin
                    state_nxt = mac_pkg::WB_ACTIVE;
                    push      = 1'b1;
                end
            end
            mac_pkg::WB_CLEAR: begin
                err_set = START_CALC | CLR_REQ;
                if (clr_cnt == CW'(mac_pkg::DEPTH - 1)) state_nxt = mac_pkg::WB_IDLE;
            end
            mac_pkg::WB_ACTIVE: begin
                push    = START_CALC;
                err_set = CLR_REQ;
                // The last row is being written this cycle once nothing remains in the delay line.
                if (!sr_busy && !START_CALC) state_nxt = mac_pkg::WB_IDLE;
            end
            default: state_nxt = mac_pkg::WB_IDLE;
        endcase
    end

    // The first row of a burst takes base/acc straight from the ports; later rows use the latched copy.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = push;
        tag_in.addr  = {(row_cnt == '0) ? ODST[3:2] : base_q, row_cnt};
        tag_in.acc   = (row_cnt == '0) ? ACC : acc_q;
    end

    always_comb begin
        arr_ext = '0;
        acc_sum = '0;
        for (int k = 0; k < 4; k++) begin
            arr_ext[k*OW +: OW] = OW'($signed(ARR_DATA[k*AW +: AW]));
            acc_sum[k*OW +: OW] = OM_RDATA[k*OW +: OW] + r_data[k*OW +: OW];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= mac_pkg::WB_IDLE;
            row_cnt <= '0;
            base_q  <= '0;
            acc_q   <= 1'b0;
            clr_cnt <= '0;
            r_valid <= 1'b0;
            r_acc   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= (state == mac_pkg::WB_CLEAR) ? clr_cnt + CW'(1) : '0;
            if (push) begin
                row_cnt <= row_cnt + RW'(1);
                if (row_cnt == '0) begin
                    base_q <= ODST[3:2];
                    acc_q  <= ACC;
                end
            end else begin
                row_cnt <= '0;
            end
            r_valid <= tag_out.valid;
            r_acc   <= tag_out.acc;
            r_addr  <= tag_out.addr;
            r_data  <= arr_ext;
            done_q  <= r_valid && (r_addr[RW-1:0] == RW'(mac_pkg::TILE - 1));
            err_q   <= err_q | err_set;
        end
    end

    assign OM_REN   = tag_out.valid & tag_out.acc;
    assign OM_RADDR = OM_REN ? tag_out.addr : '0;
    assign OM_WEN   = (state == mac_pkg::WB_CLEAR) | r_valid;

    always_comb begin
        OM_WADDR = '0;
        OM_WDATA = '0;
        if (state == mac_pkg::WB_CLEAR) begin
            OM_WADDR = clr_cnt;
        end else if (r_valid) begin
            OM_WADDR = r_addr;
            OM_WDATA = r_acc ? acc_sum : r_data;
        end
    end

    assign Tile_Done = done_q;
    assign BUSY      = (state != mac_pkg::WB_IDLE);
    assign ERR       = err_q;
endmodule

// File: tb/tb_omem_writeback.sv
// tb/tb_omem_writeback.sv - directed bench with a memory-level reference model for omem_writeback
module tb_omem_writeback;
    localparam int LAT = 3;
    localparam int AW  = 20;
    localparam int OW  = 24;

    logic            CLK = 1'b0;
    logic            RST, CLR_REQ, START_CALC, ACC;
    logic [3:0]      ODST;
    logic [4*AW-1:0] ARR_DATA;
    logic [4*OW-1:0] OM_RDATA;
    logic            OM_REN, OM_WEN, Tile_Done, BUSY, ERR;
    logic [3:0]      OM_RADDR, OM_WADDR;
    logic [4*OW-1:0] OM_WDATA;

    omem_writeback #(.LAT(LAT), .AW(AW), .OW(OW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CLR_REQ    (CLR_REQ),
        .START_CALC (START_CALC),
        .ODST       (ODST),
        .ACC        (ACC),
        .ARR_DATA   (ARR_DATA),
        .OM_RDATA   (OM_RDATA),
        .OM_REN     (OM_REN),
        .OM_WEN     (OM_WEN),
        .OM_RADDR   (OM_RADDR),
        .OM_WADDR   (OM_WADDR),
        .OM_WDATA   (OM_WDATA),
        .Tile_Done  (Tile_Done),
        .BUSY       (BUSY),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    bit  chk_en = 1'b0;
    bit  err_exp = 1'b0;

    logic [4*OW-1:0] ram [16];
    logic [4*OW-1:0] em  [16];
    logic [4*AW-1:0] arr_at   [int];
    logic [3:0]      exp_wa   [int];
    bit              exp_wacc [int];
    logic [4*OW-1:0] exp_wd   [int];
    bit              exp_done [int];
    bit              busy_at  [int];
    int              done_log [$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    logic            ren_n = 1'b0, wen_n = 1'b0, ew, er;
    logic [3:0]      raddr_n = '0, waddr_n = '0, a;
    logic [4*OW-1:0] wdata_n = '0, expd, wd, old;

    // Compare every cycle: writes, reads, Tile_Done, BUSY and ERR against the model.
    always @(negedge CLK) begin
        ren_n   = OM_REN;
        raddr_n = OM_RADDR;
        wen_n   = OM_WEN;
        waddr_n = OM_WADDR;
        wdata_n = OM_WDATA;
        if (Tile_Done) done_log.push_back(cyc);
        if (chk_en && !RST) begin
            ew = exp_wa.exists(cyc);
            chk("om_wen", OM_WEN, ew);
            if (ew && OM_WEN) begin
                a   = exp_wa[cyc];
                wd  = exp_wd[cyc];
                old = em[a];
                for (int k = 0; k < 4; k++)
                    expd[k*OW +: OW] = exp_wacc[cyc] ? old[k*OW +: OW] + wd[k*OW +: OW] : wd[k*OW +: OW];
                em[a] = expd;
                chk("om_waddr", OM_WADDR, a);
                chk("om_wdata", OM_WDATA, expd);
            end
            er = exp_wa.exists(cyc + 1) && exp_wacc[cyc + 1];
            chk("om_ren", OM_REN, er);
            if (er && OM_REN) chk("om_raddr", OM_RADDR, exp_wa[cyc + 1]);
            chk("tile_done", Tile_Done, exp_done.exists(cyc));
            chk("busy", BUSY, busy_at.exists(cyc));
            chk("err", ERR, err_exp);
        end
    end

    // Bench-owned output memory and MAC array result source.
    always @(posedge CLK) begin
        #1;
        if (ren_n) OM_RDATA = ram[raddr_n];
        else       OM_RDATA = {$urandom, $urandom, $urandom};
        if (wen_n) ram[waddr_n] = wdata_n;
        ARR_DATA = arr_at.exists(cyc) ? arr_at[cyc] : 80'({$urandom, $urandom, $urandom});
    end

    task automatic burst(input logic [3:0] odst, input bit acc, input int nrows,
                         input int b, input int ls, input int rs);
        logic [4*AW-1:0] d;
        logic [4*OW-1:0] x;
        int c, v;
        for (int r = 0; r < nrows; r++) begin
            c = cyc;
            for (int k = 0; k < 4; k++) begin
                v = b + k * ls + r * rs;
                d[k*AW +: AW] = AW'(v);
                x[k*OW +: OW] = OW'(v);
            end
            START_CALC = 1'b1;
            ODST = (r == 0) ? odst : 4'($urandom);
            ACC  = (r == 0) ? acc : 1'($urandom);
            arr_at[c + LAT]       = d;
            exp_wa[c + LAT + 1]   = {odst[3:2], 2'(r)};
            exp_wacc[c + LAT + 1] = acc;
            exp_wd[c + LAT + 1]   = x;
            for (int i = c + 1; i <= c + LAT + 1; i++) busy_at[i] = 1'b1;
            if (r == 3) exp_done[c + LAT + 2] = 1'b1;
            step();
        end
        START_CALC = 1'b0;
    endtask

    task automatic do_clear(input int viol_at);
        int c;
        c = cyc;
        CLR_REQ = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_wa[c + 1 + i]   = 4'(i);
            exp_wacc[c + 1 + i] = 1'b0;
            exp_wd[c + 1 + i]   = '0;
            busy_at[c + 1 + i]  = 1'b1;
        end
        step();
        CLR_REQ = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == viol_at) START_CALC = 1'b1;
            step();
            if (i == viol_at) begin
                START_CALC = 1'b0;
                err_exp = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        chk_en = 1'b0;
        START_CALC = 1'b0;
        CLR_REQ = 1'b0;
        exp_wa.delete();
        exp_wacc.delete();
        exp_wd.delete();
        exp_done.delete();
        busy_at.delete();
        err_exp = 1'b0;
        step();
        step();
        RST = 1'b0;
        chk_en = 1'b1;
    endtask

    int s, n_before;

    initial begin
        RST = 1'b1; CLR_REQ = 1'b0; START_CALC = 1'b0; ACC = 1'b0; ODST = '0;
        ARR_DATA = '0; OM_RDATA = '0;
        for (int i = 0; i < 16; i++) begin
            ram[i] = {$urandom, $urandom, $urandom};
            em[i]  = ram[i];
        end
        do_reset();
        @(negedge CLK);
        chk("rst_outputs", {OM_REN, OM_WEN, OM_RADDR, OM_WADDR, OM_WDATA, Tile_Done, BUSY, ERR}, '0);
        step();

        do_clear(-1);
        idle(4);
        @(negedge CLK);
        chk("clear_word5", ram[5], '0);
        chk("clear_word15", ram[15], '0);
        step();

        s = cyc;
        burst(4'b1000, 1'b0, 4, 1, 1, 0);
        idle(10);
        @(negedge CLK);
        chk("tile_a_done_cycle", done_log[$], s + LAT + 5);
        chk("tile_a_word10", ram[10], {24'd4, 24'd3, 24'd2, 24'd1});
        step();

        burst(4'b1000, 1'b1, 4, -1, 0, 0);
        idle(10);
        @(negedge CLK);
        chk("tile_b_word9", ram[9], {24'd3, 24'd2, 24'd1, 24'd0});
        step();

        for (int i = 12; i < 16; i++) begin
            ram[i] = {4{24'h7FFFFF}};
            em[i]  = ram[i];
        end
        burst(4'b1100, 1'b1, 4, 1, 0, 0);
        idle(10);
        @(negedge CLK);
        chk("wrap_word14", ram[14], {4{24'h800000}});
        step();

        burst(4'b0100, 1'b0, 2, 7, -3, 5);
        step();
        s = cyc;
        burst(4'b0000, 1'b0, 4, 100, -7, 3);
        burst(4'b0100, 1'b1, 4, -50000, 11, -13);
        idle(12);
        @(negedge CLK);
        chk("b2b_first_done", done_log[$-1], s + LAT + 5);
        chk("b2b_spacing", done_log[$] - done_log[$-1], 4);
        step();

        do_clear(4);
        @(negedge CLK);
        chk("err_after_clear", ERR, 1'b1);
        step();
        n_before = done_log.size();
        burst(4'b1000, 1'b0, 2, 5, 5, 5);
        do_reset();
        idle(15);
        @(negedge CLK);
        chk("err_cleared", ERR, 1'b0);
        chk("no_done_after_rst", done_log.size(), n_before);
        step();

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/omem_writeback.md
# omem_writeback

Output-memory writeback stage that sits directly downstream of the tile controller and the 4×4 MAC array. For each tile calculation burst it tags the array's result rows with output-memory addresses and aligns them to the array's pipeline latency. It writes or read-modify-write-accumulates each row into the 16-word output memory, then returns the one-cycle `Tile_Done` pulse that advances the controller's tile pointer. It also performs the 16-word zero sweep requested at job start.

## Interface
- `LAT`, 3: cycles from a `START_CALC` cycle to its result row on `ARR_DATA`; legal range 1–8.
- `AW`, 20: signed lane width of one MAC array output.
- `OW`, 24: signed lane width stored in output memory; must be ≥ `AW`.
- `CLK`  in  1  sole clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `CLR_REQ`  in  1  pulse; starts the zero sweep of all 16 output words.
- `START_CALC`  in  1  high for 4 consecutive cycles per tile, one cycle per result row.
- `ODST`  in  4  output tile address; only `ODST[3:2]` ({m,t}) is used, sampled on the first `START_CALC` cycle of a burst.
- `ACC`  in  1  1 = accumulate onto stored data (second n-tile); 0 = overwrite. Sampled with `ODST`.
- `ARR_DATA`  in  4*AW  4 signed result lanes; lane k is bits [k*AW +: AW].
- `OM_RDATA`  in  4*OW  output-memory read data, valid 1 cycle after a read enable.
- `OM_REN`, `OM_WEN`  out  1 each  output-memory read / write strobes.
- `OM_RADDR`, `OM_WADDR`  out  4 each  output-memory addresses.
- `OM_WDATA`  out  4*OW  output-memory write data.
- `Tile_Done`  out  1  one-cycle pulse after the 4th row of a tile is written.
- `BUSY`  out  1  high while clearing or while any row is in flight.
- `ERR`  out  1  sticky protocol-violation flag; cleared only by `RST`.

## Operation
- States: `IDLE`, `CLEAR`, `ACTIVE`.
- **`IDLE`**
  - `CLR_REQ` → `CLEAR`.
  - `START_CALC` → `ACTIVE`.
  - If both are high in the same cycle, `CLEAR` wins and `ERR` is set.
- **`CLEAR`**
  - 16 cycles writing zero to addresses 0..15 in ascending order via `OM_WEN`/`OM_WADDR`.
  - Returns to `IDLE` after address 15 is written.
  - `START_CALC` or `CLR_REQ` seen in `CLEAR` is dropped and sets `ERR`.
- **Tagging**
  - On each `START_CALC` cycle the block pushes {valid, base={ODST[3:2]} latched on the burst's first cycle, row counter, ACC latched} into an `LAT`-deep shift register.
  - The row counter counts 0..3, resets to 0 after row 3, and resets to 0 if a burst ends early.
- **Row arrival**
  - The tag arrives when its shift-register entry exits, aligned with the matching `ARR_DATA`.
  - The block registers `ARR_DATA`, sign-extended per lane to `OW`, together with the tag.
- **Overwrite path (tag ACC = 0)**
  - Cycle k+1: write address {base,row} with the extended data.
  - No read is issued.
- **Accumulate path (tag ACC = 1)**
  - Cycle k: `OM_REN` with `OM_RADDR` = {base,row}.
  - Cycle k+1: `OM_WEN` with `OM_WDATA` = per-lane `OM_RDATA` + extended data, modulo 2^OW (no saturation).
  - A row's read overlaps the previous row's write. Addresses within a tile are distinct, so no forwarding is required.
- **Tile completion**
  - `Tile_Done` pulses the cycle after the write of row 3.
  - `ACTIVE` → `IDLE` once the shift register is empty and the last write is done.
- A new `START_CALC` burst while `ACTIVE` with rows still in flight is legal and simply queues into the shift register.

## Timing
- Values after `RST`: state `IDLE`; shift register cleared; row counter 0; `ERR`=0.
- All outputs are 0 after `RST`: `OM_REN`, `OM_WEN`, addresses, `OM_WDATA`, `Tile_Done`, `BUSY`.
- Reset asserted mid-tile or mid-clear discards all in-flight rows. No `Tile_Done` is emitted for them.
- Latency:
  - Row arrival = `START_CALC` cycle + `LAT`.
  - Write = arrival + 1.
  - For a burst starting at cycle s, `Tile_Done` = s + 3 + `LAT` + 2.
- `BUSY` rises the cycle after `CLR_REQ` or the first `START_CALC` is accepted, and falls with the final write or final clear cycle.

## Structure
- Shared package `mac_pkg`:
  - `AW`, `OW`, tile size 4, output depth 16.
  - State encoding `wb_state_t`.
  - Tag struct {valid, addr[3:0], acc}.
- One natural sub-module: `tag_delay`, a parameterised `LAT`-deep shift register of the tag struct.
- Lane adders and sign extension stay inline.

## Test plan
- Reset, then `CLR_REQ` → writes of 0 to addresses 0..15 on 16 consecutive cycles; `BUSY` high throughout; no `Tile_Done`.
- `ODST`=4'b1000, `ACC`=0, 4-cycle `START_CALC`, lane data 1,2,3,4 per row → writes to addresses 8..11 with exactly that data; `Tile_Done` at s+`LAT`+5.
- Repeat the same tile with `ACC`=1 and data −1 in all lanes → reads of addresses 8..11, writes of 0,1,2,3; read/write overlap in every cycle.
- Accumulate with stored 0x7FFFFF plus 1 (`OW`=24) → written value 0x800000 (wrap, no saturation).
- Back-to-back bursts: second `START_CALC` one cycle after the first burst ends → two `Tile_Done` pulses 4 cycles apart; no missed writes.
- `START_CALC` during `CLEAR`, then `RST` mid-tile → `ERR`=1 until reset; after reset no writes and no `Tile_Done`.
